// File: rtl/hazard_ctrl_gen2.sv
// Hazard controller for a five-stage in-order pipeline.
// Detects load-use hazards against the load sitting in ID/EX, inserts
// LOAD_LAT bubbles per hazard, flushes younger stages on a taken branch and
// freezes everything while data memory is busy. Two saturating counters
// report stall cycles and accepted branch redirects.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | no bubbles owed; a load-use hazard here inserts the first one
// LSTALL  | rem_q more bubbles owed for the current load-use hazard
module hazard_ctrl_gen2 #(
   parameter int REG_AW      = 5,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] rs1_id,
   input  logic [REG_AW-1:0] rs2_id,
   input  logic              rs1_used,
   input  logic              rs2_used,
   input  logic              idex_valid,
   input  logic              idex_mem_read,
   input  logic [REG_AW-1:0] idex_rd,
   input  logic              branch_taken,
   input  logic              mem_busy,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_write,
   output logic              exmem_write,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_events
);

   localparam int               REM_W    = $clog2(LOAD_LAT + 1);
   // Bubbles still owed after the first one, which is issued from RUN.
   localparam logic [REM_W-1:0] REM_LOAD = REM_W'(LOAD_LAT - 1);
   localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_LSTALL = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  flush_q, flush_d;
   logic              lu;
   logic              branch_acc;

   // Register 0 is hardwired to zero, so a load targeting it never blocks ID.
   assign lu = id_valid & idex_valid & idex_mem_read & (idex_rd != '0) &
               ((rs1_used & (rs1_id == idex_rd)) |
                (rs2_used & (rs2_id == idex_rd)));

   // Next-state and pipeline control in priority order:
   // reset, memory freeze, branch redirect, load-use bubble, normal flow.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      state_d     = state_q;
      rem_d       = rem_q;
      branch_acc  = 1'b0;

      if (rst) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         state_d     = ST_RUN;
         rem_d       = '0;
      end else if (mem_busy) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
      end else if (branch_taken) begin
         // A redirect kills whatever the stalled instruction was waiting on,
         // so any outstanding bubbles are dropped.
         ifid_flush  = 1'b1;
         idex_flush  = (FLUSH_DEPTH >= 2);
         exmem_flush = (FLUSH_DEPTH == 3);
         state_d     = ST_RUN;
         rem_d       = '0;
         branch_acc  = 1'b1;
      end else if (state_q == ST_LSTALL) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_flush  = 1'b1;
         if (rem_q <= REM_ONE) begin
            state_d = ST_RUN;
            rem_d   = '0;
         end else begin
            rem_d   = rem_q - REM_ONE;
         end
      end else if (lu) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_flush  = 1'b1;
         if (LOAD_LAT > 1) begin
            state_d = ST_LSTALL;
            rem_d   = REM_LOAD;
         end
      end
   end

   // Saturating performance counters; a frozen PC counts as a stall cycle.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!pc_write && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + CNT_ONE;
      end
      if (branch_acc && (flush_q != CNT_MAX)) begin
         flush_d = flush_q + CNT_ONE;
      end
   end

   // State, bubble count and counters, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         rem_q   <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl_gen2.sv
// Bench for hazard_ctrl_gen2: four instances with different bubble counts,
// flush depths and counter widths share one stimulus stream. A reference
// model tracks, per instance, the number of bubbles still owed and the two
// counters; directed scenarios add hand-derived expectations on top.
module tb_hazard_ctrl_gen2;

   logic       clk = 1'b0;
   logic       rst, id_valid, rs1_used, rs2_used;
   logic       idex_valid, idex_mem_read, branch_taken, mem_busy;
   logic [4:0] rs1_id, rs2_id, idex_rd;

   logic pc_w [4];
   logic ifid_w [4];
   logic idex_w [4];
   logic exmem_w [4];
   logic ifid_f [4];
   logic idex_f [4];
   logic exmem_f [4];
   logic [15:0] st0, st1, st2, fe0, fe1, fe2;
   logic [3:0]  st3, fe3;

   int n_tests = 0;
   int n_fail  = 0;

   int pend [4];
   int stall_m [4];
   int flush_m [4];

   always #5 clk = ~clk;

   hazard_ctrl_gen2 #(.LOAD_LAT(1), .FLUSH_DEPTH(2)) u0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .idex_valid(idex_valid),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .branch_taken(branch_taken),
      .mem_busy(mem_busy), .pc_write(pc_w[0]), .ifid_write(ifid_w[0]),
      .idex_write(idex_w[0]), .exmem_write(exmem_w[0]), .ifid_flush(ifid_f[0]),
      .idex_flush(idex_f[0]), .exmem_flush(exmem_f[0]),
      .stall_cycles(st0), .flush_events(fe0));

   hazard_ctrl_gen2 #(.LOAD_LAT(3), .FLUSH_DEPTH(1)) u1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .idex_valid(idex_valid),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .branch_taken(branch_taken),
      .mem_busy(mem_busy), .pc_write(pc_w[1]), .ifid_write(ifid_w[1]),
      .idex_write(idex_w[1]), .exmem_write(exmem_w[1]), .ifid_flush(ifid_f[1]),
      .idex_flush(idex_f[1]), .exmem_flush(exmem_f[1]),
      .stall_cycles(st1), .flush_events(fe1));

   hazard_ctrl_gen2 #(.LOAD_LAT(3), .FLUSH_DEPTH(3)) u2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .idex_valid(idex_valid),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .branch_taken(branch_taken),
      .mem_busy(mem_busy), .pc_write(pc_w[2]), .ifid_write(ifid_w[2]),
      .idex_write(idex_w[2]), .exmem_write(exmem_w[2]), .ifid_flush(ifid_f[2]),
      .idex_flush(idex_f[2]), .exmem_flush(exmem_f[2]),
      .stall_cycles(st2), .flush_events(fe2));

   hazard_ctrl_gen2 #(.LOAD_LAT(4), .FLUSH_DEPTH(2), .CNT_W(4)) u3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .idex_valid(idex_valid),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .branch_taken(branch_taken),
      .mem_busy(mem_busy), .pc_write(pc_w[3]), .ifid_write(ifid_w[3]),
      .idex_write(idex_w[3]), .exmem_write(exmem_w[3]), .ifid_flush(ifid_f[3]),
      .idex_flush(idex_f[3]), .exmem_flush(exmem_f[3]),
      .stall_cycles(st3), .flush_events(fe3));

   function automatic int lat_of(int i);
      case (i)
         0:       return 1;
         1, 2:    return 3;
         default: return 4;
      endcase
   endfunction

   function automatic int fd_of(int i);
      case (i)
         1:       return 1;
         2:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int cmax_of(int i);
      return (i == 3) ? 15 : 65535;
   endfunction

   function automatic logic [6:0] dut_vec(int i);
      return {pc_w[i], ifid_w[i], idex_w[i], exmem_w[i], ifid_f[i], idex_f[i], exmem_f[i]};
   endfunction

   function automatic int dut_stall(int i);
      case (i)
         0:       return int'(st0);
         1:       return int'(st1);
         2:       return int'(st2);
         default: return int'(st3);
      endcase
   endfunction

   function automatic int dut_flush(int i);
      case (i)
         0:       return int'(fe0);
         1:       return int'(fe1);
         2:       return int'(fe2);
         default: return int'(fe3);
      endcase
   endfunction

   // A load in ID/EX blocks ID if ID really reads the nonzero register it writes.
   function automatic bit lu_m();
      bit hit1, hit2;
      if (!(id_valid && idex_valid && idex_mem_read)) return 1'b0;
      if (idex_rd == 5'd0) return 1'b0;
      hit1 = rs1_used && (rs1_id == idex_rd);
      hit2 = rs2_used && (rs2_id == idex_rd);
      return hit1 || hit2;
   endfunction

   // Expected {pc, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f}.
   function automatic logic [6:0] exp_vec(int i);
      logic [6:0] v;
      if (rst)                          v = 7'b1111_111;
      else if (mem_busy)                v = 7'b0000_000;
      else if (branch_taken)            v = {4'b1111, 1'b1, fd_of(i) >= 2, fd_of(i) == 3};
      else if (pend[i] > 0 || lu_m())   v = 7'b0011_010;
      else                              v = 7'b1111_000;
      return v;
   endfunction

   task automatic model_update();
      bit lu;
      lu = lu_m();
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            pend[i] = 0; stall_m[i] = 0; flush_m[i] = 0;
         end else if (mem_busy) begin
            if (stall_m[i] < cmax_of(i)) stall_m[i]++;
         end else if (branch_taken) begin
            pend[i] = 0;
            if (flush_m[i] < cmax_of(i)) flush_m[i]++;
         end else if (pend[i] > 0 || lu) begin
            pend[i] = (pend[i] > 0) ? pend[i] - 1 : lat_of(i) - 1;
            if (stall_m[i] < cmax_of(i)) stall_m[i]++;
         end
      end
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      id_valid = 0; rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0;
      idex_valid = 0; idex_mem_read = 0; idex_rd = 0;
      branch_taken = 0; mem_busy = 0;
   endtask

   task automatic set_lu();
      set_idle();
      id_valid = 1; rs1_id = 5; rs1_used = 1;
      idex_valid = 1; idex_mem_read = 1; idex_rd = 5;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1;
      @(negedge clk);
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dut_vec(i) !== 7'b1111_111) begin
               n_fail++;
               $display("FAIL reset_vec u%0d: got %b want 1111111", i, dut_vec(i));
            end
            if (c == 1) begin
               n_tests++;
               if (dut_stall(i) !== 0 || dut_flush(i) !== 0) begin
                  n_fail++;
                  $display("FAIL reset_cnt u%0d: got stall %0d flush %0d want 0 0",
                           i, dut_stall(i), dut_flush(i));
               end
            end
         end
         tick();
      end
      rst = 0;
   endtask

   task automatic test_load_use();
      do_reset();
      set_lu();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (pc_w[i] !== (c >= lat_of(i)) || idex_f[i] !== (c < lat_of(i))) begin
               n_fail++;
               $display("FAIL load_use u%0d cyc %0d: got pc %b idex_flush %b want pc %b",
                        i, c, pc_w[i], idex_f[i], c >= lat_of(i));
            end
         end
         tick();
         if (c == 0) set_idle();
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (dut_stall(i) !== lat_of(i)) begin
            n_fail++;
            $display("FAIL load_use_stalls u%0d: got %0d want %0d", i, dut_stall(i), lat_of(i));
         end
      end
   endtask

   task automatic test_no_hazard();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_idle();
         id_valid = 1; idex_valid = 1; idex_mem_read = 1;
         case (k)
            0: begin idex_rd = 0; rs1_id = 0; rs2_id = 0; rs1_used = 1; rs2_used = 1; end
            1: begin idex_rd = 7; rs1_id = 3; rs1_used = 1; rs2_id = 7; rs2_used = 0; end
            default: begin idex_rd = 7; rs1_id = 3; rs1_used = 1; rs2_id = 7; rs2_used = 1; end
         endcase
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (pc_w[i] !== (k != 2)) begin
               n_fail++;
               $display("FAIL no_hazard case %0d u%0d: got pc %b want %b", k, i, pc_w[i], k != 2);
            end
         end
         tick();
      end
      set_idle();
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_branch_in_lstall();
      logic [6:0] want;
      do_reset();
      set_lu();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            case (c)
               0: want = 7'b0011_010;
               1: want = (lat_of(i) > 1) ? 7'b0011_010 : 7'b1111_000;
               2: want = (fd_of(i) == 1) ? 7'b1111_100 :
                         (fd_of(i) == 2) ? 7'b1111_110 : 7'b1111_111;
               default: want = 7'b1111_000;
            endcase
            n_tests++;
            if (dut_vec(i) !== want) begin
               n_fail++;
               $display("FAIL branch_lstall u%0d cyc %0d: got %b want %b", i, c, dut_vec(i), want);
            end
            if (c == 3) begin
               n_tests++;
               if (dut_flush(i) !== 1) begin
                  n_fail++;
                  $display("FAIL branch_lstall_cnt u%0d: got %0d want 1", i, dut_flush(i));
               end
            end
         end
         tick();
         set_idle();
         branch_taken = (c == 1);
      end
   endtask

   task automatic test_mem_busy();
      do_reset();
      set_lu();
      @(negedge clk);
      tick();
      set_idle();
      mem_busy = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dut_vec(i) !== 7'b0000_000) begin
               n_fail++;
               $display("FAIL mem_busy_freeze u%0d cyc %0d: got %b want 0000000", i, c, dut_vec(i));
            end
         end
         tick();
      end
      mem_busy = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (pc_w[i] !== (c >= lat_of(i) - 1)) begin
               n_fail++;
               $display("FAIL mem_busy_resume u%0d cyc %0d: got pc %b want %b",
                        i, c, pc_w[i], c >= lat_of(i) - 1);
            end
         end
         tick();
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (dut_stall(i) !== 4 + lat_of(i)) begin
            n_fail++;
            $display("FAIL mem_busy_stalls u%0d: got %0d want %0d", i, dut_stall(i), 4 + lat_of(i));
         end
      end
   endtask

   task automatic test_flush_depth();
      logic [2:0] want;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         if (c == 0) begin set_idle(); branch_taken = 1; end
         else if (c == 1) begin set_lu(); branch_taken = 1; end
         else set_idle();
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            want = (c == 2) ? 3'b000 :
                   (fd_of(i) == 1) ? 3'b100 : (fd_of(i) == 2) ? 3'b110 : 3'b111;
            n_tests++;
            if (dut_vec(i) !== {4'b1111, want}) begin
               n_fail++;
               $display("FAIL flush_depth u%0d cyc %0d: got %b want %b", i, c, dut_vec(i), {4'b1111, want});
            end
            if (c == 2) begin
               n_tests++;
               if (dut_flush(i) !== 2 || dut_stall(i) !== 0) begin
                  n_fail++;
                  $display("FAIL flush_depth_cnt u%0d: got flush %0d stall %0d want 2 0",
                           i, dut_flush(i), dut_stall(i));
               end
            end
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      mem_busy = 1;
      for (int c = 0; c < 20; c++) begin @(negedge clk); tick(); end
      set_idle();
      branch_taken = 1;
      for (int c = 0; c < 18; c++) begin @(negedge clk); tick(); end
      set_idle();
      @(negedge clk);
      n_tests++;
      if (st3 !== 4'd15 || fe3 !== 4'd15) begin
         n_fail++;
         $display("FAIL saturate_narrow: got stall %0d flush %0d want 15 15", st3, fe3);
      end
      n_tests++;
      if (st0 !== 16'd20 || fe0 !== 16'd18) begin
         n_fail++;
         $display("FAIL saturate_wide: got stall %0d flush %0d want 20 18", st0, fe0);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_lu();
      @(negedge clk);
      tick();
      set_idle();
      mem_busy = 1;
      @(negedge clk);
      tick();
      rst = 1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (dut_vec(i) !== 7'b1111_111) begin
            n_fail++;
            $display("FAIL reset_mid_vec u%0d: got %b want 1111111", i, dut_vec(i));
         end
      end
      tick();
      rst = 0;
      mem_busy = 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (dut_vec(i) !== 7'b1111_000 || dut_stall(i) !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_after u%0d: got %b stall %0d want 1111000 0",
                     i, dut_vec(i), dut_stall(i));
         end
      end
      tick();
   endtask

   task automatic test_random();
      logic [6:0] want;
      for (int c = 0; c < 600; c++) begin
         rst           = ($urandom_range(0, 99) < 2);
         mem_busy      = ($urandom_range(0, 99) < 15);
         branch_taken  = ($urandom_range(0, 99) < 10);
         id_valid      = ($urandom_range(0, 99) < 85);
         idex_valid    = ($urandom_range(0, 99) < 85);
         idex_mem_read = ($urandom_range(0, 99) < 50);
         rs1_used      = $urandom_range(0, 1);
         rs2_used      = $urandom_range(0, 1);
         rs1_id        = 5'($urandom_range(0, 3));
         rs2_id        = 5'($urandom_range(0, 3));
         idex_rd       = 5'($urandom_range(0, 3));
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            want = exp_vec(i);
            n_tests++;
            if (dut_vec(i) !== want) begin
               n_fail++;
               $display("FAIL random_vec u%0d cyc %0d: got %b want %b", i, c, dut_vec(i), want);
            end
            n_tests++;
            if (dut_stall(i) !== stall_m[i] || dut_flush(i) !== flush_m[i]) begin
               n_fail++;
               $display("FAIL random_cnt u%0d cyc %0d: got stall %0d flush %0d want %0d %0d",
                        i, c, dut_stall(i), dut_flush(i), stall_m[i], flush_m[i]);
            end
         end
         tick();
      end
      rst = 0;
      set_idle();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         pend[i] = 0; stall_m[i] = 0; flush_m[i] = 0;
      end
      test_reset();
      test_load_use();
      test_no_hazard();
      test_branch_in_lstall();
      test_mem_busy();
      test_flush_depth();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_gen2.md
HAZARD_CTRL_GEN2 -- requirements
Module: hazard_ctrl_gen2

Interface
REQ-001 The block SHALL provide the following parameters, one per line: name, default, meaning.
- REG_AW, 5, register address width.
- LOAD_LAT, 1, bubbles per load-use hazard, legal 1..4.
- FLUSH_DEPTH, 2, registers flushed on a taken branch: 1 = IF/ID; 2 = IF/ID + ID/EX; 3 = IF/ID + ID/EX + EX/MEM.
- CNT_W, 16, performance counter width.
REQ-002 The block SHALL provide the following ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- rs1_id, rs2_id  in  REG_AW  ID source registers.
- rs1_used, rs2_used  in  1  source register actually read.
- idex_valid  in  1  ID/EX holds a real instruction.
- idex_mem_read  in  1  ID/EX instruction is a load.
- idex_rd  in  REG_AW  ID/EX destination register.
- branch_taken  in  1  redirect resolved in EX this cycle.
- mem_busy  in  1  data memory wait; freezes the pipeline.
- pc_write, ifid_write, idex_write, exmem_write  out  1  pipeline register enables.
- ifid_flush, idex_flush, exmem_flush  out  1  bubble insertion into each register.
- stall_cycles  out  CNT_W  cycles with pc_write = 0.
- flush_events  out  CNT_W  accepted taken branches.

Function
REQ-003 The load-use hazard (LU) SHALL be: id_valid & idex_valid & idex_mem_read & idex_rd != 0 & ((rs1_used & rs1_id == idex_rd) | (rs2_used & rs2_id == idex_rd)).
REQ-004 The FSM SHALL have two states, RUN and LSTALL, plus a remaining-bubble counter rem of width clog2(LOAD_LAT+1).
REQ-005 Output priority SHALL be: rst > mem_busy > branch_taken > LU or LSTALL > normal.
REQ-006 While mem_busy = 1, all four write enables SHALL be 0 and all flushes 0. State, rem and flush_events SHALL hold, and branch_taken and LU SHALL be ignored.
REQ-007 When branch_taken = 1 and mem_busy = 0:
- pc_write, ifid_write, idex_write and exmem_write SHALL be 1.
- ifid_flush SHALL be 1; idex_flush SHALL be 1 iff FLUSH_DEPTH >= 2; exmem_flush SHALL be 1 iff FLUSH_DEPTH = 3.
- The next state SHALL be RUN with rem = 0, aborting any LSTALL.
REQ-008 In RUN with LU, no branch_taken and no mem_busy:
- pc_write = 0, ifid_write = 0, idex_flush = 1, idex_write = 1, exmem_write = 1.
- If LOAD_LAT > 1, next state SHALL be LSTALL with rem = LOAD_LAT-1; otherwise the state SHALL remain RUN.
REQ-009 In LSTALL, with no branch_taken and no mem_busy:
- Outputs SHALL be identical to REQ-008, independent of LU.
- rem SHALL decrement each cycle; the state SHALL return to RUN in the cycle after rem reaches 1.
REQ-010 The total consecutive bubbles per load-use hazard SHALL equal LOAD_LAT, excluding mem_busy cycles.
REQ-011 In RUN with no event, all write enables SHALL be 1 and all flushes 0.
REQ-012 All control outputs SHALL be combinational from state, rem and inputs; state, rem and the counters SHALL be registered.
REQ-013 stall_cycles SHALL increment by 1 on each non-reset cycle with pc_write = 0, including mem_busy cycles, and SHALL saturate at 2^CNT_W-1.
REQ-014 flush_events SHALL increment on each cycle where REQ-007 applies and SHALL saturate at all-ones.
REQ-015 A register index of 0 SHALL never cause a hazard.
REQ-016 LU in the same cycle as branch_taken SHALL produce no bubble and no LSTALL entry.

Reset
REQ-017 While rst = 1, the outputs SHALL be: pc_write = 1, ifid_write = 1, idex_write = 1, exmem_write = 1, and all three flushes = 1.
REQ-018 On a clock edge with rst = 1, the state SHALL become RUN, rem 0, stall_cycles 0 and flush_events 0.
REQ-019 rst asserted mid-LSTALL or mid-mem_busy SHALL abandon the operation; the first cycle after rst deasserts SHALL behave as RUN with no pending bubbles.

Verification
REQ-020 LOAD_LAT=1: load rd=5 in ID/EX, ID reads rs1=5 -> exactly one cycle pc_write=0, idex_flush=1; stall_cycles=1.
REQ-021 LOAD_LAT=3: same stimulus, LU removed after cycle 1 -> three consecutive stall cycles, then RUN; stall_cycles=3.
REQ-022 LOAD_LAT=3: branch_taken in the second LSTALL cycle -> that cycle flushes per FLUSH_DEPTH with pc_write=1; next cycle normal; flush_events=1.
REQ-023 Matching idex_rd=0, or match with rs2_used=0 on rs2 -> no stall.
REQ-024 mem_busy held 4 cycles during LSTALL (rem=2) -> enables 0, flushes 0, rem held; after release 2 bubbles remain; stall_cycles counts 4 + 3.
REQ-025 FLUSH_DEPTH=1/2/3 with branch_taken -> flush vectors (ifid, idex, exmem) = 100/110/111.
